vga_timing: RTL

//   Raster timing generator directly upstream of the pixel/graphics stage. Produces the

---
 rtl/vga_timing.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/vga_timing.sv
// Raster timing generator: beam position, syncs, active flag, line/frame strobes and a
// frame counter, all registered and decoded from the same next-state position.
`timescale 1ns/1ps
module vga_timing #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FRONT_PORCH   = 16,
    parameter int H_SYNC_PULSE    = 96,
    parameter int H_BACK_PORCH    = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_SYNC_PULSE    = 2,
    parameter int V_BACK_PORCH    = 33,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int FRAME_BITS      = 8,
    localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
    localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
    localparam int XB      = $clog2(H_TOTAL),
    localparam int YB      = $clog2(V_TOTAL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic [XB-1:0]         pixel_x,
    output logic [YB-1:0]         pixel_y,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  active,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [FRAME_BITS-1:0] frame_counter
);

    localparam int HS_BEG = H_ACTIVE + H_FRONT_PORCH;
    localparam int HS_END = HS_BEG + H_SYNC_PULSE;
    localparam int VS_BEG = V_ACTIVE + V_FRONT_PORCH;
    localparam int VS_END = VS_BEG + V_SYNC_PULSE;

    localparam logic [XB-1:0] X_LAST = XB'(H_TOTAL - 1);
    localparam logic [YB-1:0] Y_LAST = YB'(V_TOTAL - 1);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = ~SYNC_ON;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [XB-1:0]         x_q, x_d;
    logic [YB-1:0]         y_q, y_d;
    logic                  hs_q, hs_d;
    logic                  vs_q, vs_d;
    logic                  act_q, act_d;
    logic                  ls_q, ls_d;
    logic                  fs_q, fs_d;
    logic [FRAME_BITS-1:0] fc_q, fc_d;
    logic                  step;

    // Range decodes widen by one bit so an end bound equal to 2^XB / 2^YB cannot wrap.
    function automatic logic x_in(input logic [XB-1:0] x, input int lo, input int hi);
        return ({1'b0, x} >= (XB+1)'(lo)) && ({1'b0, x} < (XB+1)'(hi));
    endfunction

    function automatic logic y_in(input logic [YB-1:0] y, input int lo, input int hi);
        return ({1'b0, y} >= (YB+1)'(lo)) && ({1'b0, y} < (YB+1)'(hi));
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        fc_d    = fc_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        act_d   = act_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        step    = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                    step    = 1'b1;
                end
            end
            RUN: begin
                if (enable) begin
                    step = 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d  = '0;
                            fc_d = fc_q + FRAME_BITS'(1);
                        end else begin
                            y_d = y_q + YB'(1);
                        end
                    end else begin
                        x_d = x_q + XB'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flags are refreshed only on an advance so a frozen raster keeps its levels.
        if (step) begin
            hs_d  = x_in(x_d, HS_BEG, HS_END) ? SYNC_ON : SYNC_OFF;
            vs_d  = y_in(y_d, VS_BEG, VS_END) ? SYNC_ON : SYNC_OFF;
            act_d = x_in(x_d, 0, H_ACTIVE) && y_in(y_d, 0, V_ACTIVE);
            ls_d  = (x_d == '0);
            fs_d  = (x_d == '0) && (y_d == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= SYNC_OFF;
            vs_q    <= SYNC_OFF;
            act_q   <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            act_q   <= act_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign pixel_x       = x_q;
    assign pixel_y       = y_q;
    assign hsync         = hs_q;
    assign vsync         = vs_q;
    assign active        = act_q;
    assign line_start    = ls_q;
    assign frame_start   = fs_q;
    assign frame_counter = fc_q;

endmodule
